fir_capture_bram: RTL and testbench
===================================

// Module: fir_capture_bram
// PURPOSE
//  Downstream stage of fir_filter: records a burst of filtered samples into an
//  inferred block RAM on command, then serves random-access readback.
//  Sits between the FIR output and the readout/host-interface logic of the lab3 top.
// PARAMETERS
//  NB_DATA  8   sample width, signed two's complement
//  NB_ADDR  10  address width; capture depth DEPTH = 2**NB_ADDR samples
// PORTS
//  i_clock    in   1        system clock (100 MHz)
//  i_reset    in   1        asynchronous, active-high reset
//  i_en       in   1        sample valid (same enable driving fir_filter)
//  i_signal   in   NB_DATA  filtered sample from fir_filter.o_signal
//  i_run      in   1        single-cycle start-capture pulse
//  i_rd_addr  in   NB_ADDR  readback address
//  o_rd_data  out  NB_DATA  readback data, 1-cycle latency
//  o_busy     out  1        high while waiting for trigger or capturing
//  o_done     out  1        high once DEPTH samples are stored; held until next i_run
// BEHAVIOUR
//  - States: IDLE, WAIT_TRIG (macro only), CAPTURE, DONE. Reset -> IDLE.
//  - Reset values: o_rd_data=0, o_busy=0, o_done=0, wr_ptr=0, prev sample=0.
//    RAM contents are not cleared by reset.
//  - IDLE/DONE + i_run -> CAPTURE (WAIT_TRIG with macro); wr_ptr<=0; o_done<=0.
//  - i_run while busy is ignored; capture is not restarted.
//  - CAPTURE: each cycle with i_en=1 writes i_signal to RAM[wr_ptr]; wr_ptr++.
//    The sample present in the i_run cycle is never captured; the first stored
//    sample is the first i_en=1 after the i_run cycle.
//  - Write at wr_ptr=DEPTH-1 -> DONE next cycle: o_busy=0, o_done=1.
//    wr_ptr wraps to 0 and does not advance in DONE; no further writes.
//  - o_busy = (state==WAIT_TRIG || state==CAPTURE), registered.
//  - Read port: always active. o_rd_data <= RAM[i_rd_addr] every cycle.
//    Read and write to the same address in the same cycle returns the OLD data
//    (read-first).
//  - i_en=0 stalls capture indefinitely; no timeout.
//  - i_reset asserted mid-capture aborts: IDLE, flags cleared, partial data stays in RAM.
//  - No arithmetic on data; samples are stored bit-exact at NB_DATA bits.
// CONFIGURATION
//  CAPTURE_TRIGGER_EN defined:
//    - i_run enters WAIT_TRIG (o_busy=1).
//    - A prev-sample register updates on every i_en=1 (reset 0).
//    - Trigger = rising zero crossing: i_en=1, prev<0 and i_signal>=0.
//    - The trigger sample is written to address 0; next state is CAPTURE with wr_ptr=1.
//    - In the i_run cycle, prev is loaded/held normally but no trigger is evaluated.
//  CAPTURE_TRIGGER_EN undefined:
//    - WAIT_TRIG and the prev register are absent; i_run goes straight to CAPTURE.
// STRUCTURE
//  - fir_bram_pkg.vh (shared include): state encodings ST_IDLE/ST_WAIT_TRIG/
//    ST_CAPTURE/ST_DONE, default NB_DATA/NB_ADDR.
//  - One sub-module: bram_sdp (simple dual-port RAM, parameterised NB_DATA/NB_ADDR;
//    one write port, one registered read-first read port; must infer BRAM).
//  - Top holds the FSM, wr_ptr and the optional trigger logic.
// TESTING (bench with NB_ADDR=4, DEPTH=16; FIR enabled; i_en=1 unless stated)
//  1. Reset, then i_run with i_signal ramp 0..40 -> o_busy 1 cycle after i_run.
//     o_done after 16 writes; RAM[k] equals the k-th sample after the i_run cycle.
//  2. Readback: sweep i_rd_addr 0..15 after done -> o_rd_data matches stored values,
//     one cycle late.
//  3. Toggle i_en 1/0 during capture -> exactly 16 writes, done after 32 cycles;
//     i_run pulse mid-capture -> no restart, wr_ptr unaffected.
//  4. Assert i_reset at write 7 -> o_busy=0 and o_done=0 immediately, async;
//     RAM[0..6] retain data; new i_run captures a fresh 16.
//  5. (macro) Sequence -3,-1,2,5 after i_run -> RAM[0]=2, RAM[1]=5.
//     Input staying >=0 -> o_busy held high and o_done stays 0.
//  6. Read addr 3 while writing addr 3 -> o_rd_data = old value; new value on the next read.

Source files
------------

// File: rtl/fir_capture_bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_capture_bram_pkg
//  Description : Shared state encodings and default geometry for the FIR
//                capture buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_capture_bram_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Default sample width and address width (depth = 2**NB_ADDR)
    localparam int C_NB_DATA_DEF = 8;
    localparam int C_NB_ADDR_DEF = 10;

endpackage : fir_capture_bram_pkg
`default_nettype wire

// File: rtl/fir_capture_bram_sdp.sv
`default_nettype none
// ============================================================================
//  Module      : fir_capture_bram_sdp
//  Description : Simple dual-port RAM, one write port and one registered
//                read-first read port, written so that it maps onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_capture_bram_sdp
    import fir_capture_bram_pkg::*;
#(
    parameter int NB_DATA = C_NB_DATA_DEF,
    parameter int NB_ADDR = C_NB_ADDR_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);

    localparam int C_DEPTH = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] r_mem [C_DEPTH];

    // Write port: contents are never cleared, partial captures survive reset
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: always enabled; sampling before the write lands gives read-first
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule : fir_capture_bram_sdp
`default_nettype wire

// File: rtl/fir_capture_bram.sv
`default_nettype none
// ============================================================================
//  Module      : fir_capture_bram
//  Description : Records a burst of 2**NB_ADDR filtered samples into block RAM
//                on an i_run pulse and serves random-access readback.
//                Optional macro CAPTURE_TRIGGER_EN: after i_run, wait for a
//                rising zero crossing before capturing (trigger sample goes
//                to address 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_capture_bram
    import fir_capture_bram_pkg::*;
#(
    parameter int NB_DATA = C_NB_DATA_DEF,
    parameter int NB_ADDR = C_NB_ADDR_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic [NB_DATA-1:0] i_signal,
    input  logic               i_run,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] C_LAST_ADDR = {NB_ADDR{1'b1}};

    state_t             r_state;
    logic [NB_ADDR-1:0] r_wr_ptr;
    logic               w_we;
    logic [NB_ADDR-1:0] w_wr_addr;

`ifdef CAPTURE_TRIGGER_EN
    logic [NB_DATA-1:0] r_prev;
    logic               w_trig;

    // Previous valid sample, tracked on every enable regardless of state
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_prev <= '0;
        end else if (i_en) begin
            r_prev <= i_signal;
        end
    end

    // Rising zero crossing: previous sample negative, current one non-negative
    assign w_trig = i_en && r_prev[NB_DATA-1] && !i_signal[NB_DATA-1];
`endif

    // Write strobe/address: stream writes in CAPTURE, trigger sample to address 0
    always_comb begin
        w_we      = 1'b0;
        w_wr_addr = r_wr_ptr;
        if (r_state == ST_CAPTURE && i_en) begin
            w_we = 1'b1;
        end
`ifdef CAPTURE_TRIGGER_EN
        if (r_state == ST_WAIT_TRIG && w_trig) begin
            w_we      = 1'b1;
            w_wr_addr = '0;
        end
`endif
    end

    // Capture controller with registered busy/done flags
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_run) begin
                        r_wr_ptr <= '0;
                        o_done   <= 1'b0;
                        o_busy   <= 1'b1;
`ifdef CAPTURE_TRIGGER_EN
                        r_state  <= ST_WAIT_TRIG;
`else
                        r_state  <= ST_CAPTURE;
`endif
                    end
                end
`ifdef CAPTURE_TRIGGER_EN
                ST_WAIT_TRIG: begin
                    if (w_trig) begin
                        r_wr_ptr <= NB_ADDR'(1);
                        r_state  <= ST_CAPTURE;
                    end
                end
`endif
                ST_CAPTURE: begin
                    // Pointer wraps to zero on the last write and stays there in DONE
                    if (i_en) begin
                        r_wr_ptr <= r_wr_ptr + NB_ADDR'(1);
                        if (r_wr_ptr == C_LAST_ADDR) begin
                            r_state <= ST_DONE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    fir_capture_bram_sdp #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_ram (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (i_signal),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

endmodule : fir_capture_bram
`default_nettype wire

// File: tb/tb_fir_capture_bram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_capture_bram
//  Description : Self-checking bench for fir_capture_bram (NB_ADDR=4,
//                depth 16) against a sample-queue reference model.
//                Honours CAPTURE_TRIGGER_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_capture_bram;

    localparam int NB_DATA = 8;
    localparam int NB_ADDR = 4;
    localparam int DEPTH   = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en  = 1'b0;
    logic               run = 1'b0;
    logic [NB_DATA-1:0] sig = '0;
    logic [NB_ADDR-1:0] ra  = '0;
    logic [NB_DATA-1:0] rd;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    fir_capture_bram #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_en      (en),
        .i_signal  (sig),
        .i_run     (run),
        .i_rd_addr (ra),
        .o_rd_data (rd),
        .o_busy    (busy),
        .o_done    (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what memory should hold and where the capture stands
    logic [NB_DATA-1:0]        m_mem   [DEPTH];
    bit                        m_known [DEPTH];
    bit                        m_cap   = 1'b0;
    bit                        m_wait  = 1'b0;
    bit                        m_done  = 1'b0;
    int                        m_n     = 0;
    logic signed [NB_DATA-1:0] m_prev  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference by one clock with the given inputs
    task automatic model_step(input bit e, input logic [NB_DATA-1:0] s, input bit r);
        if (!m_cap && !m_wait) begin
            if (r) begin
                m_done = 1'b0;
                m_n    = 0;
`ifdef CAPTURE_TRIGGER_EN
                m_wait = 1'b1;
`else
                m_cap  = 1'b1;
`endif
            end
        end else if (m_wait) begin
            if (e && m_prev < 0 && $signed(s) >= 0) begin
                m_mem[0]   = s;
                m_known[0] = 1'b1;
                m_n        = 1;
                m_wait     = 1'b0;
                m_cap      = 1'b1;
            end
        end else if (e) begin
            m_mem[m_n]   = s;
            m_known[m_n] = 1'b1;
            m_n++;
            if (m_n == DEPTH) begin
                m_cap  = 1'b0;
                m_done = 1'b1;
                m_n    = 0;
            end
        end
`ifdef CAPTURE_TRIGGER_EN
        if (e) m_prev = s;
`endif
    endtask

    // One clock: drive at negedge, check flags and one-cycle-late readback after posedge
    task automatic cycle(input bit e, input logic [NB_DATA-1:0] s, input bit r,
                         input logic [NB_ADDR-1:0] a);
        logic [NB_DATA-1:0] exp_rd;
        bit                 exp_known;
        @(negedge clk);
        en = e; sig = s; run = r; ra = a;
        exp_known = m_known[a];
        exp_rd    = m_mem[a];
        model_step(e, s, r);
        @(posedge clk);
        #1;
        check_eq("busy", {31'd0, busy}, {31'd0, (m_cap || m_wait)});
        check_eq("done", {31'd0, done}, {31'd0, m_done});
        if (exp_known) check_eq("rd_data", {24'd0, rd}, {24'd0, exp_rd});
    endtask

    // Asynchronous reset applied between clock edges; flags must drop at once
    task automatic async_reset();
        @(negedge clk);
        run = 1'b0; en = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_cap = 1'b0; m_wait = 1'b0; m_done = 1'b0; m_n = 0; m_prev = '0;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_rd",   {24'd0, rd},   32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue i_run; with the trigger option, follow with a negative sample to arm it
    task automatic start_capture(input logic [NB_DATA-1:0] s);
        cycle(1'b1, s, 1'b1, NB_ADDR'($urandom));
`ifdef CAPTURE_TRIGGER_EN
        cycle(1'b1, 8'hFF, 1'b0, NB_ADDR'($urandom));
`endif
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]   = '0;
            m_known[k] = 1'b0;
        end

        // Reset state
        async_reset();

        // Ramp capture: sample in the i_run cycle is skipped
        start_capture(8'd0);
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b1, NB_DATA'(i), 1'b0, NB_ADDR'($urandom));
        end

        // Readback sweep, including a pass with i_en toggling randomly
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'($urandom), NB_DATA'($urandom), 1'b0, NB_ADDR'(k));
        end

        // Alternating enable, mid-capture run pulse, read-while-write on the same address
        start_capture(NB_DATA'($urandom));
        for (int i = 0; i < 32; i++) begin
            logic [NB_ADDR-1:0] a;
            a = (i % 2 == 0) ? NB_ADDR'(m_n) : NB_ADDR'(m_n - 1);
            cycle((i % 2) == 0, NB_DATA'($urandom), (i == 10), a);
        end
`ifndef CAPTURE_TRIGGER_EN
        check_eq("t3_done_after_32", {31'd0, done}, 32'd1);
`endif

        // Abort after 7 writes; earlier data must remain readable
        start_capture(NB_DATA'($urandom));
        for (int i = 0; i < 400 && m_n < 7; i++) begin
            cycle(1'b1, NB_DATA'($urandom), 1'b0, NB_ADDR'($urandom));
        end
        async_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 8'h00, 1'b0, NB_ADDR'(k));
        end
        start_capture(NB_DATA'($urandom));
        for (int i = 0; i < 400 && (m_cap || m_wait); i++) begin
            cycle(1'($urandom), NB_DATA'($urandom), 1'b0, NB_ADDR'($urandom));
        end
        check_eq("t4_recapture_done", {31'd0, done}, 32'd1);

`ifdef CAPTURE_TRIGGER_EN
        // Zero-crossing trigger: -3,-1,2,5 stores 2 then 5
        cycle(1'b1, 8'h00, 1'b1, 4'd0);
        cycle(1'b1, 8'hFD, 1'b0, 4'd0);
        cycle(1'b1, 8'hFF, 1'b0, 4'd0);
        cycle(1'b1, 8'h02, 1'b0, 4'd0);
        cycle(1'b1, 8'h05, 1'b0, 4'd0);
        cycle(1'b1, 8'h07, 1'b0, 4'd0);
        cycle(1'b1, 8'h07, 1'b0, 4'd1);
        cycle(1'b1, 8'h07, 1'b0, 4'd1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, NB_DATA'($urandom_range(0, 127)), 1'b0, NB_ADDR'($urandom));
        end
        // Non-negative input never triggers
        cycle(1'b1, 8'h10, 1'b1, 4'd0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, NB_DATA'($urandom_range(0, 127)), 1'b0, NB_ADDR'($urandom));
        end
        check_eq("t5_still_busy", {31'd0, busy}, 32'd1);
        async_reset();
`endif

        // Random soak: sparse run pulses, random enable and read addresses
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom), NB_DATA'($urandom), ($urandom_range(0, 19) == 0),
                  NB_ADDR'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fir_capture_bram
`default_nettype wire
